// File: rtl/bus_responder85_pkg.sv
// Shared definitions for the 8085-style bus responder: cycle status codes,
// FSM encoding, decoded target kinds and the port slice width.
package bus_responder85_pkg;

   // {IO/M_, S1, S0} status codes
   localparam logic [2:0] ST_HALT = 3'b000;
   localparam logic [2:0] ST_MW   = 3'b001;
   localparam logic [2:0] ST_MR   = 3'b010;
   localparam logic [2:0] ST_OF   = 3'b011;
   localparam logic [2:0] ST_DW   = 3'b101;
   localparam logic [2:0] ST_DR   = 3'b110;
   localparam logic [2:0] ST_INA  = 3'b111;

   localparam int PORT_W = 8;

   typedef enum logic [1:0] {IDLE, ADDR, XFER, END} state_e;

   typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_IO, SEL_ACK} sel_e;

endpackage

// File: rtl/bus_responder85_ram.sv
// Byte-wide RAM behind the memory window: asynchronous read, synchronous write.
module busresp_ram
   import bus_responder85_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk_,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [PORT_W-1:0] wdata,
   output logic [PORT_W-1:0] rdata
);

   logic [PORT_W-1:0] mem [2**AW];

   always_ff @(posedge clk_) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/bus_responder85.sv
// Bus-side responder for the 8085 multiplexed bus: RAM window, I/O ports, wait states.
// Optional interrupt-acknowledge response is enabled with `define BUSRESP_INTA_EN.
module bus_responder85
   import bus_responder85_pkg::*;
#(
   parameter int          MEM_AW   = 8,
   parameter logic [15:0] MEM_BASE = 16'h0000,
   parameter logic [7:0]  IO_BASE  = 8'h10,
   parameter int          IO_CNT   = 4,
   parameter int          WAITS    = 1,
   parameter logic [7:0]  INTVEC   = 8'hFF
) (
   input  logic                     clk_,
   input  logic                     rst_,
   input  logic [7:0]               a_hi,
   input  logic [7:0]               ad_in,
   output logic [7:0]               ad_out,
   output logic                     ad_oe,
   input  logic                     ale,
   input  logic                     s0,
   input  logic                     s1,
   input  logic                     iom_,
   input  logic                     rd_,
   input  logic                     wr_,
   input  logic                     inta_,
   output logic                     ready,
   output logic [PORT_W*IO_CNT-1:0] port_q
);

`ifdef BUSRESP_INTA_EN
   localparam bit ACK_ON = 1'b1;
`else
   localparam bit ACK_ON = 1'b0;
`endif

   state_e             state;
   sel_e               sel;
   sel_e               dec_sel;
   logic [2:0]         wcnt;
   logic [MEM_AW-1:0]  mem_addr;
   logic [3:0]         port_idx;
   logic [PORT_W-1:0]  ports [IO_CNT];
   logic [PORT_W-1:0]  ram_q;
   logic [PORT_W-1:0]  port_rd;
   logic [2:0]         stat_in;
   logic [15:0]        addr_in;
   logic [8:0]         io_off;
   logic               rd_act, wr_act, inta_act, any_act, wr_commit, relatch;

   // Strobes are active only on a solid 0; z or x reads as inactive.
   assign rd_act   = (rd_ === 1'b0);
   assign wr_act   = (wr_ === 1'b0);
   assign inta_act = (inta_ === 1'b0);
   assign any_act  = rd_act | wr_act | inta_act;

   assign stat_in  = {iom_, s1, s0};
   assign addr_in  = {a_hi, ad_in};
   // Below IO_BASE wraps to a large 9-bit value, so one compare covers both bounds.
   assign io_off   = {1'b0, ad_in} - {1'b0, IO_BASE};
   assign relatch  = ale && (state == IDLE || state == END);

   always_comb begin
      dec_sel = SEL_NONE;
      case (stat_in)
         ST_OF, ST_MR, ST_MW:
            if ((addr_in >> MEM_AW) == (MEM_BASE >> MEM_AW)) dec_sel = SEL_MEM;
         ST_DR, ST_DW:
            if (io_off < 9'(IO_CNT)) dec_sel = SEL_IO;
         ST_INA:
            dec_sel = ACK_ON ? SEL_ACK : SEL_NONE;
         ST_HALT:
            dec_sel = SEL_NONE;
         default:
            dec_sel = SEL_NONE;
      endcase
   end

   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         state <= IDLE;
         wcnt  <= 3'd0;
         sel   <= SEL_NONE;
      end else begin
         case (state)
            IDLE, END: begin
               // ALE in END restarts decode when the master skipped the strobe release
               if (ale) begin
                  sel   <= dec_sel;
                  wcnt  <= (dec_sel != SEL_NONE) ? 3'(WAITS) : 3'd0;
                  state <= (dec_sel != SEL_NONE) ? ADDR : IDLE;
               end else if (state == END && !any_act) begin
                  state <= IDLE;
               end
            end
            ADDR: begin
               if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
               else if (any_act) state <= XFER;
            end
            XFER:    state <= END;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_) begin
      if (relatch) begin
         mem_addr <= addr_in[MEM_AW-1:0];
         port_idx <= io_off[3:0];
      end
   end

   // XFER lasts exactly one clock, so the write lands once per cycle.
   assign wr_commit = (state == XFER) && wr_act;

   busresp_ram #(.AW(MEM_AW)) u_ram (
      .clk_  (clk_),
      .we    (wr_commit && sel == SEL_MEM),
      .addr  (mem_addr),
      .wdata (ad_in),
      .rdata (ram_q)
   );

   always_ff @(posedge clk_ or posedge rst_) begin
      if (rst_) begin
         for (int k = 0; k < IO_CNT; k++) ports[k] <= '0;
      end else if (wr_commit && sel == SEL_IO) begin
         for (int k = 0; k < IO_CNT; k++)
            if (port_idx == 4'(k)) ports[k] <= ad_in;
      end
   end

   always_comb begin
      port_rd = '0;
      for (int k = 0; k < IO_CNT; k++) begin
         port_q[k*PORT_W +: PORT_W] = ports[k];
         if (port_idx == 4'(k)) port_rd = ports[k];
      end
   end

   assign ready = !(state == ADDR && wcnt != 3'd0);

   always_comb begin
      ad_oe  = 1'b0;
      ad_out = '0;
      if (state == XFER || state == END) begin
         case (sel)
            SEL_MEM: if (rd_act)   begin ad_oe = 1'b1; ad_out = ram_q;   end
            SEL_IO:  if (rd_act)   begin ad_oe = 1'b1; ad_out = port_rd; end
            SEL_ACK: if (inta_act) begin ad_oe = 1'b1; ad_out = INTVEC;  end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_responder85.sv
// Self-checking bench for bus_responder85: two instances (0 and 3 wait states)
// share one bus master; a behavioural memory/port model predicts every response.
module tb_bus_responder85;

   localparam logic [15:0] MEM_BASE = 16'h2000;
   localparam int          MEM_SZ   = 256;
   localparam int          IO_BASE  = 16;
   localparam int          IO_CNT   = 4;
`ifdef BUSRESP_INTA_EN
   localparam bit INTA_ON = 1'b1;
`else
   localparam bit INTA_ON = 1'b0;
`endif

   localparam int T_OF = 0, T_MR = 1, T_MW = 2, T_DR = 3, T_DW = 4, T_INA = 5;

   logic        clk_ = 1'b0;
   logic        rst_;
   logic [7:0]  a_hi, ad_in;
   logic        ale, s0, s1, iom_, rd_, wr_, inta_;
   logic [7:0]  out0, out3;
   logic        oe0, oe3, rdy0, rdy3;
   logic [31:0] pq0, pq3;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem_m [MEM_SZ];
   bit         mem_v [MEM_SZ];
   logic [7:0] port_m [IO_CNT];

   always #5 clk_ = ~clk_;

   bus_responder85 #(.MEM_AW(8), .MEM_BASE(MEM_BASE), .IO_BASE(8'h10), .IO_CNT(IO_CNT),
                     .WAITS(0), .INTVEC(8'hFF)) u_w0 (
      .clk_(clk_), .rst_(rst_), .a_hi(a_hi), .ad_in(ad_in), .ad_out(out0), .ad_oe(oe0),
      .ale(ale), .s0(s0), .s1(s1), .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_),
      .ready(rdy0), .port_q(pq0));

   bus_responder85 #(.MEM_AW(8), .MEM_BASE(MEM_BASE), .IO_BASE(8'h10), .IO_CNT(IO_CNT),
                     .WAITS(3), .INTVEC(8'hFF)) u_w3 (
      .clk_(clk_), .rst_(rst_), .a_hi(a_hi), .ad_in(ad_in), .ad_out(out3), .ad_oe(oe3),
      .ale(ale), .s0(s0), .s1(s1), .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_),
      .ready(rdy3), .port_q(pq3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_window(input logic [15:0] a);
      return (int'(a) >= int'(MEM_BASE)) && (int'(a) < int'(MEM_BASE) + MEM_SZ);
   endfunction

   function automatic bit in_io(input logic [7:0] lo);
      return (int'(lo) >= IO_BASE) && (int'(lo) < IO_BASE + IO_CNT);
   endfunction

   function automatic logic [31:0] exp_ports();
      logic [31:0] v;
      for (int k = 0; k < IO_CNT; k++) v[k*8 +: 8] = port_m[k];
      return v;
   endfunction

   task automatic bus_cycle(input int typ, input logic [15:0] a, input logic [7:0] d,
                            input string tag);
      logic [2:0] st;
      bit         is_rd, is_wr, is_ack, hit, exp_oe;
      logic [7:0] exp_d;
      int         lo0, lo3, n;
      case (typ)
         T_OF:    st = 3'b011;
         T_MR:    st = 3'b010;
         T_MW:    st = 3'b001;
         T_DR:    st = 3'b110;
         T_DW:    st = 3'b101;
         default: st = 3'b111;
      endcase
      is_rd  = (typ == T_OF || typ == T_MR || typ == T_DR);
      is_wr  = (typ == T_MW || typ == T_DW);
      is_ack = (typ == T_INA);
      if (typ == T_OF || typ == T_MR || typ == T_MW) hit = in_window(a);
      else if (typ == T_DR || typ == T_DW)          hit = in_io(a[7:0]);
      else                                          hit = INTA_ON;
      exp_d = 8'h00;
      if (hit && is_ack) exp_d = 8'hFF;
      else if (hit && is_rd && typ == T_DR) exp_d = port_m[int'(a[7:0]) - IO_BASE];
      else if (hit && is_rd) exp_d = mem_m[int'(a) - int'(MEM_BASE)];
      exp_oe = hit && (is_rd || is_ack);

      // T1: address and status with ALE
      @(negedge clk_);
      ale = 1'b1; a_hi = a[15:8]; ad_in = a[7:0]; {iom_, s1, s0} = st;
      rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
      // T2 onwards: strobe low, count the clocks each responder holds READY low
      @(negedge clk_);
      ale = 1'b0; ad_in = is_wr ? d : 8'h00;
      rd_ = !is_rd; wr_ = !is_wr; inta_ = !is_ack;
      #1;
      lo0 = 0; lo3 = 0; n = 0;
      while (n < 16 && !(rdy0 && rdy3)) begin
         if (!rdy0) lo0++;
         if (!rdy3) lo3++;
         @(negedge clk_); #1;
         n++;
      end
      chk({tag, " ready-low clocks w0"}, lo0, 0);
      chk({tag, " ready-low clocks w3"}, lo3, hit ? 3 : 0);
      @(negedge clk_); #1;
      chk({tag, " ad_oe w0"}, oe0, exp_oe);
      chk({tag, " ad_oe w3"}, oe3, exp_oe);
      if (exp_oe) begin
         chk({tag, " ad_out w0"}, out0, exp_d);
         chk({tag, " ad_out w3"}, out3, exp_d);
      end
      if (hit && typ == T_MW) begin
         mem_m[int'(a) - int'(MEM_BASE)] = d;
         mem_v[int'(a) - int'(MEM_BASE)] = 1'b1;
      end
      if (hit && typ == T_DW) port_m[int'(a[7:0]) - IO_BASE] = d;
      @(negedge clk_);
      rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
      #1;
      chk({tag, " released ad_oe w0"}, oe0, 1'b0);
      chk({tag, " released ad_oe w3"}, oe3, 1'b0);
      chk({tag, " port_q w0"}, pq0, exp_ports());
      chk({tag, " port_q w3"}, pq3, exp_ports());
   endtask

   task automatic halt_cycle();
      @(negedge clk_);
      ale = 1'b1; a_hi = 8'h20; ad_in = 8'h05; {iom_, s1, s0} = 3'b000;
      @(negedge clk_);
      ale = 1'b0; rd_ = 1'bz; wr_ = 1'bz; inta_ = 1'bz; ad_in = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("halt ready w0", rdy0, 1'b1);
         chk("halt ready w3", rdy3, 1'b1);
         chk("halt ad_oe w0", oe0, 1'b0);
         chk("halt ad_oe w3", oe3, 1'b0);
         @(negedge clk_);
      end
      rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int          typ;

      for (int i = 0; i < MEM_SZ; i++) mem_v[i] = 1'b0;
      for (int k = 0; k < IO_CNT; k++) port_m[k] = 8'h00;
      rst_ = 1'b1; ale = 1'b0; a_hi = 8'h00; ad_in = 8'h00;
      {iom_, s1, s0} = 3'b000; rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
      repeat (2) @(negedge clk_);
      rst_ = 1'b0;
      #1;
      chk("reset ready w0", rdy0, 1'b1);
      chk("reset ready w3", rdy3, 1'b1);
      chk("reset ad_oe w3", oe3, 1'b0);
      chk("reset ad_out w3", out3, 8'h00);
      chk("reset port_q w3", pq3, 32'h0);

      bus_cycle(T_MW, 16'h2005, 8'hA5, "mem write 2005");
      bus_cycle(T_MR, 16'h2005, 8'h00, "mem read 2005");
      bus_cycle(T_MW, 16'h2000, 8'h5A, "mem write 2000");
      bus_cycle(T_OF, 16'h2000, 8'h00, "opcode fetch 2000");
      bus_cycle(T_DW, 16'h0012, 8'h3C, "io write 12");
      chk("port 2 byte", pq3[23:16], 8'h3C);
      bus_cycle(T_DR, 16'h0012, 8'h00, "io read 12");
      bus_cycle(T_DR, 16'hA713, 8'h00, "io read mirrored 13");
      bus_cycle(T_DR, 16'h0020, 8'h00, "io read 20");
      bus_cycle(T_MW, 16'h4005, 8'h77, "mem write 4005");
      halt_cycle();
      bus_cycle(T_MR, 16'h2005, 8'h00, "mem read 2005 after foreign");
      bus_cycle(T_INA, 16'h0000, 8'h00, "inta");

      for (int i = 0; i < 40; i++) begin
         typ = $urandom_range(0, 5);
         d   = 8'($urandom);
         if (typ == T_DR || typ == T_DW)
            a = {8'($urandom), 8'($urandom_range(12, 23))};
         else if ($urandom_range(0, 3) == 0)
            a = 16'($urandom);
         else
            a = {8'h20, 8'($urandom)};
         if ((typ == T_OF || typ == T_MR) && in_window(a) &&
             !mem_v[int'(a) - int'(MEM_BASE)])
            typ = T_MW;
         bus_cycle(typ, a, d, $sformatf("rand%0d t%0d a%h", i, typ, a));
      end

      // Reset in the middle of a 3-wait read, while the wait counter reads 2
      @(negedge clk_);
      ale = 1'b1; a_hi = 8'h20; ad_in = 8'h05; {iom_, s1, s0} = 3'b010;
      @(negedge clk_);
      ale = 1'b0; ad_in = 8'h00; rd_ = 1'b0;
      @(negedge clk_);
      #1;
      chk("pre-reset ready w3 low", rdy3, 1'b0);
      rst_ = 1'b1;
      #1;
      chk("mid-reset ready w3", rdy3, 1'b1);
      chk("mid-reset ad_oe w0", oe0, 1'b0);
      chk("mid-reset ad_oe w3", oe3, 1'b0);
      @(negedge clk_);
      rst_ = 1'b0;
      for (int k = 0; k < IO_CNT; k++) port_m[k] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("post-reset ready w3", rdy3, 1'b1);
         chk("post-reset ad_oe w0", oe0, 1'b0);
         chk("post-reset ad_oe w3", oe3, 1'b0);
         @(negedge clk_);
      end
      rd_ = 1'b1;
      #1;
      chk("post-reset port_q w0", pq0, 32'h0);
      bus_cycle(T_MR, 16'h2005, 8'h00, "mem read after reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
